// File: rtl/branch_pkg.sv
// Shared definitions for the conditional-branch sequencer: opcodes, FSM states
// and the branch condition / target helpers.
package branch_pkg;

    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_BLE = 6'h06;
    localparam logic [5:0] OP_BGT = 6'h07;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMP  = 3'd1,
        EVAL = 3'd2,
        UPD  = 3'd3,
        FIN  = 3'd4
    } state_e;

    function automatic logic is_branch(input logic [5:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGT);
    endfunction

    function automatic logic branch_cond(input logic [5:0] op, input logic igual,
                                         input logic maior);
        logic res;
        res = 1'b0;
        case (op)
            OP_BEQ:  res = igual;
            OP_BNE:  res = !igual;
            OP_BLE:  res = !maior;
            OP_BGT:  res = maior;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Word offset is sign-extended and scaled to bytes; wraps mod 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                  input logic [15:0] off);
        return pc + {{14{off[15]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/branch_seq_if.sv
// Signal bundle between the control unit / ALU / PC path and the branch sequencer.
interface branch_seq_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             start;
    logic [5:0]       opcode;
    logic [15:0]      offset;
    logic [31:0]      pc_plus4;
    logic             igual;
    logic             maior;
    logic             alu_cmp;
    logic             busy;
    logic             pc_write;
    logic [31:0]      pc_target;
    logic             taken;
    logic             done;
    logic             bad_op;
    logic [CNT_W-1:0] cnt_taken;
    logic [CNT_W-1:0] cnt_ntaken;

    modport slave (
        input  start, opcode, offset, pc_plus4, igual, maior,
        output alu_cmp, busy, pc_write, pc_target, taken, done, bad_op,
               cnt_taken, cnt_ntaken
    );

    modport master (
        output start, opcode, offset, pc_plus4, igual, maior,
        input  alu_cmp, busy, pc_write, pc_target, taken, done, bad_op,
               cnt_taken, cnt_ntaken
    );
endinterface

// File: rtl/branch_cnt_sat.sv
// Saturating event counter: counts up on inc_i and sticks at all-ones.
module branch_cnt_sat #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/branch_seq.sv
// Multi-cycle conditional-branch sequencer: ALU compare, flag evaluation,
// target computation, one-shot PC write and taken/not-taken statistics.
module branch_seq
    import branch_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic         clk,
    input  logic         reset,
    branch_seq_if.slave  bus
);
    localparam int unsigned       WAIT_W    = 3;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(ALU_LAT - 1);

    state_e              state_q, state_d;
    logic [5:0]          op_q, op_d;
    logic [15:0]         off_q, off_d;
    logic [31:0]         pc_q, pc_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                bad_q, bad_d;
    logic                taken_q, taken_d;
    logic [31:0]         target_q, target_d;
    logic                alu_cmp_q, alu_cmp_d;
    logic                busy_q, busy_d;
    logic                pc_write_q, pc_write_d;
    logic                done_q, done_d;
    logic                bad_op_q, bad_op_d;
    logic                inc_taken_c, inc_ntaken_c;
    logic [CNT_W-1:0]    cnt_taken_w, cnt_ntaken_w;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            off_q      <= '0;
            pc_q       <= '0;
            wait_q     <= '0;
            bad_q      <= 1'b0;
            taken_q    <= 1'b0;
            target_q   <= '0;
            alu_cmp_q  <= 1'b0;
            busy_q     <= 1'b0;
            pc_write_q <= 1'b0;
            done_q     <= 1'b0;
            bad_op_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            off_q      <= off_d;
            pc_q       <= pc_d;
            wait_q     <= wait_d;
            bad_q      <= bad_d;
            taken_q    <= taken_d;
            target_q   <= target_d;
            alu_cmp_q  <= alu_cmp_d;
            busy_q     <= busy_d;
            pc_write_q <= pc_write_d;
            done_q     <= done_d;
            bad_op_q   <= bad_op_d;
        end
    end

    // Registered outputs are computed from the next state so they line up with it.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        pc_d         = pc_q;
        wait_d       = wait_q;
        bad_d        = bad_q;
        taken_d      = taken_q;
        target_d     = target_q;
        pc_write_d   = 1'b0;
        done_d       = 1'b0;
        bad_op_d     = 1'b0;
        inc_taken_c  = 1'b0;
        inc_ntaken_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = bus.opcode;
                    off_d   = bus.offset;
                    pc_d    = bus.pc_plus4;
                    taken_d = 1'b0;
                    if (is_branch(bus.opcode)) begin
                        bad_d   = 1'b0;
                        wait_d  = WAIT_INIT;
                        state_d = CMP;
                    end else begin
                        // Non-branches borrow the UPD slot (no counting) so done lands two cycles out.
                        bad_d   = 1'b1;
                        state_d = UPD;
                    end
                end
            end
            CMP: begin
                if (wait_q == '0) begin
                    state_d = EVAL;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            EVAL: begin
                taken_d    = branch_cond(op_q, bus.igual, bus.maior);
                target_d   = branch_target(pc_q, off_q);
                pc_write_d = taken_d;
                state_d    = UPD;
            end
            UPD: begin
                inc_taken_c  = !bad_q && taken_q;
                inc_ntaken_c = !bad_q && !taken_q;
                done_d       = 1'b1;
                bad_op_d     = bad_q;
                state_d      = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        alu_cmp_d = (state_d == CMP) || (state_d == EVAL);
        busy_d    = (state_d != IDLE);
    end

    branch_cnt_sat #(.W(CNT_W)) u_cnt_taken (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (inc_taken_c),
        .count_o (cnt_taken_w)
    );

    branch_cnt_sat #(.W(CNT_W)) u_cnt_ntaken (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (inc_ntaken_c),
        .count_o (cnt_ntaken_w)
    );

    assign bus.alu_cmp    = alu_cmp_q;
    assign bus.busy       = busy_q;
    assign bus.pc_write   = pc_write_q;
    assign bus.pc_target  = target_q;
    assign bus.taken      = taken_q;
    assign bus.done       = done_q;
    assign bus.bad_op     = bad_op_q;
    assign bus.cnt_taken  = cnt_taken_w;
    assign bus.cnt_ntaken = cnt_ntaken_w;
endmodule
